deskew_collector_4bits: RTL and testbench
=========================================

Name: deskew_collector_4bits

Overview:
- Receiving end of the systolic-array skew path. The input skew shifter staggers operands so lane i enters the array i cycles after lane 0.
- This block takes the equally staggered result lanes leaving the array and delays lane i by (SA_NUM-1-i) cycles, so all lanes of a row line up.
- Aligned rows go into a small FIFO with a valid/ready interface toward the controller write-back path.
- It also counts rows per frame and flags dropped rows.

Parameters:
- SA_NUM, default `SA_NUM (4 for unit test): number of array lanes.
- DW, default 4: bits per lane.
- ROWS, default 16: rows per frame; must be >= 2.
- FIFO_DEPTH, default 4: aligned-row buffer depth; must be a power of 2, >= 2.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- in_data, input, [SA_NUM-1:0][DW-1:0]: skewed lane results; lane i is meaningful i cycles after its row's in_valid.
- in_valid, input, 1: marks the cycle in which lane 0 of a row is present.
- out_data, output, [SA_NUM-1:0][DW-1:0]: aligned row at FIFO head.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts the head row when out_valid && out_ready.
- out_row, output, $clog2(ROWS): row index of the head row within its frame.
- frame_done, output, 1: one-cycle pulse when the last row of a frame (out_row==ROWS-1) is popped.
- overflow, output, 1: sticky; an aligned row was dropped.

Behaviour:
- Reset: rst high asynchronously clears all of the following, and they stay cleared while rst is high:
  - lane delay registers and the valid delay chain;
  - FIFO pointers and count;
  - row counter;
  - outputs: out_valid=0, out_data=0, out_row=0, frame_done=0, overflow=0.
- Reset mid-operation: rows in flight and rows buffered are discarded; no partial output follows reset release.
- Deskew:
  - Lane i passes through (SA_NUM-1-i)+1 registers.
  - in_valid passes through SA_NUM registers to give aligned_valid.
  - If in_valid is high in cycle t, all lanes of that row are registered together and aligned_valid is high in cycle t+SA_NUM.
- FIFO write: at the end of a cycle with aligned_valid=1, the aligned row is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Latency: with the FIFO empty, out_valid rises in cycle t+SA_NUM+1, with that row at out_data.
- Throughput:
  - Back-to-back in_valid (every cycle) is supported, so one row per cycle can be accepted.
  - Rows leave the FIFO in arrival order.
- Overflow:
  - Condition: aligned_valid=1, FIFO full, and no pop in that cycle.
  - The row is dropped and overflow goes to 1 on the next cycle; it is cleared only by rst.
  - A dropped row does not advance out_row numbering.
- Pop: out_valid && out_ready removes the head.
  - out_data/out_valid are driven from the FIFO head storage (registered state, no combinational path from in_data).
  - out_ready while out_valid=0 has no effect.
- Row counter:
  - Increments on each pop and wraps ROWS-1 -> 0.
  - out_row reflects the counter, i.e. the index of the current head row.
- frame_done: registered, high for exactly the cycle after the pop of a row with out_row==ROWS-1.
- Empty/full: out_valid = (count != 0). Full = (count == FIFO_DEPTH). Count, pointers and row counter wrap modulo their widths.
- in_data with in_valid low is ignored, but still shifts through the delay lanes (no gating required). Only aligned_valid qualifies a write.

Test Plan:
(All scenarios use SA_NUM=4, DW=4, ROWS=4, FIFO_DEPTH=4.)
1. Reset: assert rst mid-cycle asynchronously -> all outputs 0 immediately. After release with no input, out_valid stays 0 for 20 cycles.
2. Single row: out_ready=1; in_valid at cycle t; lane0=1 at t, lane1=2 at t+1, lane2=3 at t+2, lane3=4 at t+3 -> out_valid only at t+5, out_data lanes {0:1,1:2,2:3,3:4}, out_row=0.
3. Full frame back-to-back: 4 rows with in_valid on consecutive cycles, lane0 values 1..4, out_ready=1 -> 4 consecutive out_valid cycles, out_row 0,1,2,3; frame_done pulses the cycle after row 3 pops; out_row returns to 0.
4. Backpressure and overflow: out_ready=0, push 5 rows -> FIFO holds rows 0-3 and overflow=1 after the 5th. Then out_ready=1 -> exactly 4 rows drain in order, and overflow stays 1.
5. Full with simultaneous pop: fill 4 rows, then push a 5th with out_ready=1 in the same cycle its aligned_valid occurs -> no overflow, all 5 rows emerge in order.
6. Reset mid-frame: after 2 rows are buffered and 1 is in flight, pulse rst -> out_valid=0 and out_row=0. The in-flight row never appears, and a new row afterwards emerges as out_row=0.

Source files
------------

// File: rtl/deskew_collector_4bits.sv
`ifndef SA_NUM
`define SA_NUM 4
`endif
// Re-aligns staggered systolic-array result lanes into rows and queues them in a small FIFO.
// First output SA_NUM+1 cycles after in_valid; a row that arrives while the FIFO is full with no pop is dropped (sticky overflow).
module deskew_collector_4bits #(
  parameter int SA_NUM     = `SA_NUM,
  parameter int DW         = 4,
  parameter int ROWS       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SA_NUM-1:0][DW-1:0]    in_data,
  input  logic                         in_valid,
  output logic [SA_NUM-1:0][DW-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(ROWS);

  logic [SA_NUM-1:0][DW-1:0] aligned;
  logic [SA_NUM-1:0]         vchain;
  logic                      aligned_valid;

  logic [SA_NUM-1:0][DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      full;
  logic                      pop;
  logic                      push;
  logic [RW-1:0]             row;

  // Lane i shows up i cycles late, so it gets SA_NUM-i stages to land with lane 0.
  for (genvar i = 0; i < SA_NUM; i++) begin : g_lane
    localparam int D = SA_NUM - i;
    logic [D-1:0][DW-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr <= '0;
      end else begin
        sr[0] <= in_data[i];
        for (int k = 1; k < D; k++) begin
          sr[k] <= sr[k-1];
        end
      end
    end

    assign aligned[i] = sr[D-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vchain <= '0;
    end else begin
      vchain <= {vchain[SA_NUM-2:0], in_valid};
    end
  end

  assign aligned_valid = vchain[SA_NUM-1];

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO can still take a row when the head leaves in the same cycle.
  assign push      = aligned_valid && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_row   = row;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= aligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row        <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= pop && (row == RW'(ROWS - 1));
      if (pop) begin
        row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
      end
      if (aligned_valid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deskew_collector_4bits.sv
// Bench for deskew_collector_4bits: skewed random rows, queue-level reference model, scoreboard monitor.
module tb_deskew_collector_4bits;

  localparam int SA   = 4;
  localparam int DW   = 4;
  localparam int ROWS = 4;
  localparam int FD   = 4;

  typedef logic [SA-1:0][DW-1:0] lanes_t;
  typedef struct { int due; lanes_t d; } arr_t;
  typedef struct { lanes_t d; int row; } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic       frame_done;
  logic       overflow;
  lanes_t     in_data = '0;
  lanes_t     out_data;
  logic [1:0] out_row;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int occ      = 0;
  int row_acc  = 0;
  bit ovf_exp  = 1'b0;
  bit fd_pending = 1'b0;

  arr_t   arrivals[$];
  exp_t   sb[$];
  lanes_t sched[SA];

  deskew_collector_4bits #(.SA_NUM(SA), .DW(DW), .ROWS(ROWS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .frame_done(frame_done), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic lanes_t rnd_lanes();
    lanes_t v;
    for (int i = 0; i < SA; i++) v[i] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  function automatic void clear_model();
    arrivals.delete();
    sb.delete();
    occ = 0;
    row_acc = 0;
    ovf_exp = 1'b0;
    for (int i = 0; i < SA; i++) sched[i] = '0;
  endfunction

  // Reference: a row issued in cycle c reaches the FIFO at the end of cycle c+SA;
  // it is kept if there is room or the head leaves in that same cycle.
  initial forever begin
    bit   pop;
    arr_t a;
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      pop = (occ > 0) && out_ready;
      if (arrivals.size() > 0 && arrivals[0].due == cyc) begin
        a = arrivals.pop_front();
        if (occ < FD || pop) begin
          sb.push_back('{d: a.d, row: row_acc});
          row_acc = (row_acc + 1) % ROWS;
          occ++;
        end else begin
          ovf_exp = 1'b1;
        end
      end
      if (pop) occ--;
    end
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_row", out_row, 0);
      chk("rst frame_done", frame_done, 0);
      chk("rst overflow", overflow, 0);
      fd_pending = 1'b0;
    end else begin
      chk("out_valid", out_valid, occ != 0);
      chk("overflow", overflow, ovf_exp);
      chk("frame_done", frame_done, fd_pending);
      fd_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL pop: DUT popped row %0h but scoreboard empty (t=%0t)", out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_row", out_row, e.row);
          fd_pending = (e.row == ROWS - 1);
        end
      end
    end
  end

  task automatic step(input bit issue, input lanes_t d, input bit rdy);
    @(posedge clk);
    #1;
    for (int k = 0; k < SA - 1; k++) sched[k] = sched[k+1];
    sched[SA-1] = rnd_lanes();
    if (issue) begin
      for (int i = 0; i < SA; i++) sched[i][i] = d[i];
      arrivals.push_back('{due: cyc + SA, d: d});
    end
    in_data   = sched[0];
    in_valid  = issue;
    out_ready = rdy;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    clear_model();
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async out_data", out_data, 0);
    chk("async out_row", out_row, 0);
    chk("async frame_done", frame_done, 0);
    chk("async overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t d;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // idle after reset
    repeat (20) step(1'b0, rnd_lanes(), 1'($urandom_range(0, 1)));

    // single row with known lanes
    step(1'b1, 16'h4321, 1'b1);
    repeat (8) step(1'b0, rnd_lanes(), 1'b1);

    // full frame back-to-back
    for (int r = 1; r <= 4; r++) begin
      d = rnd_lanes();
      d[0] = 4'(r);
      step(1'b1, d, 1'b1);
    end
    repeat (8) step(1'b0, rnd_lanes(), 1'b1);

    // backpressure into overflow, then drain
    repeat (5) step(1'b1, rnd_lanes(), 1'b0);
    repeat (8) step(1'b0, rnd_lanes(), 1'b0);
    repeat (8) step(1'b0, rnd_lanes(), 1'b1);

    async_reset();

    // full FIFO with a pop in the same cycle as the fifth arrival
    repeat (4) step(1'b1, rnd_lanes(), 1'b0);
    repeat (6) step(1'b0, rnd_lanes(), 1'b0);
    step(1'b1, rnd_lanes(), 1'b0);
    repeat (3) step(1'b0, rnd_lanes(), 1'b0);
    repeat (10) step(1'b0, rnd_lanes(), 1'b1);

    // reset with rows buffered and one in flight
    repeat (2) step(1'b1, rnd_lanes(), 1'b0);
    repeat (6) step(1'b0, rnd_lanes(), 1'b0);
    step(1'b1, rnd_lanes(), 1'b0);
    step(1'b0, rnd_lanes(), 1'b0);
    async_reset();
    step(1'b1, rnd_lanes(), 1'b1);
    repeat (8) step(1'b0, rnd_lanes(), 1'b1);

    // random traffic
    repeat (400) step(1'($urandom_range(0, 1)), rnd_lanes(), $urandom_range(0, 3) != 0);
    repeat (12) step(1'b0, rnd_lanes(), 1'b1);

    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
